// File: rtl/iis_pkg.sv
// Shared types for the I2S / left-justified receive framer: FSM states,
// channel encodings and framing-mode encodings.
package iis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2,
        SKIP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } chan_e;

    typedef enum logic {
        MODE_LJ  = 1'b0,
        MODE_I2S = 1'b1
    } mode_e;

endpackage

// File: rtl/iis_rx_shift.sv
// MSB-first serial shifter with a bit counter; o_word is the sample that a
// shift this cycle would complete, o_last flags that this shift is the final bit.
module iis_rx_shift #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_shift,
    input  logic              i_sd,
    output logic [DATA_W-1:0] o_word,
    output logic              o_last
);

    logic [DATA_W-2:0] r_sr;
    logic [CNT_W-1:0]  r_cnt;

    assign o_word = {r_sr, i_sd};
    assign o_last = (r_cnt == CNT_W'(DATA_W - 1));

    // i_start takes priority so a slot can restart in the cycle the previous word ends.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_sr  <= {{(DATA_W-2){1'b0}}, i_sd};
            r_cnt <= CNT_W'(1);
        end else if (i_shift) begin
            r_sr  <= o_word[DATA_W-2:0];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/iis_rx_framer.sv
// Serial audio receive framer (I2S or left-justified) with a valid/ready sample
// stream. Define IIS_RX_STATS_EN to build the saturating drop counter.
module iis_rx_framer
    import iis_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 32,
    parameter bit LEFT_WS = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_en,
    input  logic              ws,
    input  logic              sd,
    input  logic              mode_i2s,
    input  logic              mono,
    input  logic [31:0]       target_num,
    output logic [DATA_W-1:0] out_data,
    output logic              out_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       receive_num,
    output logic              receive_finish,
    output logic              overrun,
    output logic              frame_err,
    output logic [15:0]       drop_cnt,
    output rx_state_e         dbg_state
);

    localparam int CNT_W = $clog2(SLOT_W + 1);

    rx_state_e         r_state, w_next;
    chan_e             r_chan, w_ws_chan;
    logic              r_ws_q;
    logic              w_edge, w_take;
    logic              w_start, w_shift, w_clear, w_last, w_done, w_ferr;
    logic              w_load, w_drop;
    logic [DATA_W-1:0] w_word;
    logic [31:0]       w_num_inc;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_chan, r_out_valid, r_finish, r_overrun, r_frame_err;
    logic [31:0]       r_receive_num;

    assign w_edge    = (ws != r_ws_q);
    assign w_ws_chan = (ws == LEFT_WS) ? CH_LEFT : CH_RIGHT;
    assign w_take    = (w_ws_chan == CH_LEFT) || !mono;

    iis_rx_shift #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (w_clear),
        .i_start (w_start),
        .i_shift (w_shift),
        .i_sd    (sd),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ws_q  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ws_q  <= ws;
        end
    end

    // An edge coinciding with the final bit completes the word and restarts,
    // which is the normal case in I2S when the slot is exactly DATA_W long.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_clear = 1'b0;
        w_ferr  = 1'b0;
        w_done  = 1'b0;
        if (!rx_en) begin
            w_next  = IDLE;
            w_clear = 1'b1;
        end else begin
            if (r_state == SHIFT) begin
                if (w_edge && !w_last) begin
                    w_ferr = 1'b1;
                end else begin
                    w_shift = 1'b1;
                    w_done  = w_last;
                    if (w_last) w_next = SKIP;
                end
            end else if (r_state == SYNC) begin
                if (w_edge) begin
                    w_ferr = 1'b1;
                end else begin
                    w_start = 1'b1;
                    w_next  = SHIFT;
                end
            end
            if (w_edge) begin
                if (!w_take) begin
                    w_next = SKIP;
                end else if (mode_i2s == MODE_I2S) begin
                    w_next = SYNC;
                end else begin
                    w_start = 1'b1;
                    w_next  = SHIFT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan <= CH_LEFT;
        end else if (rx_en && w_edge) begin
            r_chan <= w_ws_chan;
        end
    end

    assign w_num_inc = r_receive_num + 32'd1;
    assign w_load    = w_done && (!r_out_valid || out_ready);
    assign w_drop    = w_done && r_out_valid && !out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data    <= '0;
            r_out_chan    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_receive_num <= '0;
            r_finish      <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else if (!rx_en) begin
            r_out_valid   <= 1'b0;
            r_receive_num <= '0;
            r_finish      <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            if (w_load) begin
                r_out_data  <= w_word;
                r_out_chan  <= r_chan;
                r_out_valid <= 1'b1;
                if ((target_num != 32'd0) && (w_num_inc == target_num)) begin
                    r_receive_num <= '0;
                    r_finish      <= 1'b1;
                end else begin
                    r_receive_num <= w_num_inc;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop) r_overrun   <= 1'b1;
            if (w_ferr) r_frame_err <= 1'b1;
        end
    end

`ifdef IIS_RX_STATS_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (!rx_en) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = 16'd0;
`endif

    assign out_data       = r_out_data;
    assign out_chan       = r_out_chan;
    assign out_valid      = r_out_valid;
    assign receive_num    = r_receive_num;
    assign receive_finish = r_finish;
    assign overrun        = r_overrun;
    assign frame_err      = r_frame_err;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_iis_rx_framer.sv
// Directed bench for iis_rx_framer: drives I2S / left-justified slots and
// compares the emitted sample stream and status against hand-computed values.
module tb_iis_rx_framer;
    import iis_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rx_en, ws, sd, mode_i2s, mono, out_ready;
    logic [31:0] target_num;
    logic [15:0] out_data;
    logic        out_chan, out_valid, receive_finish, overrun, frame_err;
    logic [31:0] receive_num;
    logic [15:0] drop_cnt;
    rx_state_e   dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    int neg_cnt = 0;
    int mark    = 0;
    int fin_cnt = 0;
    logic prev_valid = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          lat_q[$];

`ifdef IIS_RX_STATS_EN
    localparam logic [15:0] EXP_DROP = 16'd1;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    iis_rx_framer #(.DATA_W(16), .SLOT_W(32), .LEFT_WS(1'b0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_en          (rx_en),
        .ws             (ws),
        .sd             (sd),
        .mode_i2s       (mode_i2s),
        .mono           (mono),
        .target_num     (target_num),
        .out_data       (out_data),
        .out_chan       (out_chan),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .receive_num    (receive_num),
        .receive_finish (receive_finish),
        .overrun        (overrun),
        .frame_err      (frame_err),
        .drop_cnt       (drop_cnt),
        .dbg_state      (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want test end");
        $fatal(1, "watchdog expired");
    end

    // monitor: samples between edges, records handshakes and valid latency
    always @(negedge clk) begin
        #2;
        neg_cnt++;
        if (out_valid && !prev_valid) lat_q.push_back(neg_cnt - mark - 1);
        prev_valid = out_valid;
        if (out_valid && out_ready) got_q.push_back({out_chan, out_data});
        if (receive_finish) fin_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic setup(input logic i2s, input logic mono_v, input logic [31:0] tgt);
        @(negedge clk);
        rx_en = 1'b0; ws = 1'b1; sd = 1'b0;
        mode_i2s = i2s; mono = mono_v; target_num = tgt; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rx_en = 1'b1;
        @(negedge clk);
        got_q.delete(); lat_q.delete(); exp_q.delete(); fin_cnt = 0;
    endtask

    // one slot of len cycles; bit k of the slot starts at the negedge before posedge k
    task automatic drive_slot(input logic ws_lvl, input logic [15:0] word, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) mark = neg_cnt;
            ws = ws_lvl;
            if (mode_i2s) sd = (k == 0) ? ~word[15] : ((k <= 16) ? word[16-k] : 1'b0);
            else          sd = (k < 16) ? word[15-k] : 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; rx_en = 1'b1; ws = 1'b1; sd = 1'b1; mode_i2s = 1'b0;
        mono = 1'b0; out_ready = 1'b1; target_num = 32'd0;

        // reset values held while rst is high
        repeat (3) @(negedge clk);
        ws = 1'b0;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_num", receive_num, 0);
        chk("rst_fin", receive_finish, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b0;

        // I2S stereo
        setup(1'b1, 1'b0, 32'd0);
        drive_slot(1'b0, 16'hA5C3, 32);
        drive_slot(1'b1, 16'h1234, 32);
        exp_q = '{17'h0A5C3, 17'h11234};
        check_stream("i2s_stream");
        chk("i2s_lat_n", lat_q.size(), 2);
        for (int i = 0; i < lat_q.size(); i++) chk("i2s_lat", lat_q[i], 17);
        chk("i2s_num", receive_num, 2);
        chk("i2s_ovr", overrun, 0);

        // left-justified stereo
        setup(1'b0, 1'b0, 32'd0);
        drive_slot(1'b0, 16'hA5C3, 32);
        drive_slot(1'b1, 16'h1234, 32);
        exp_q = '{17'h0A5C3, 17'h11234};
        check_stream("lj_stream");
        chk("lj_lat_n", lat_q.size(), 2);
        for (int i = 0; i < lat_q.size(); i++) chk("lj_lat", lat_q[i], 16);
        chk("lj_num", receive_num, 2);

        // mono: right slots skipped
        setup(1'b0, 1'b1, 32'd0);
        drive_slot(1'b0, 16'h1357, 32); drive_slot(1'b1, 16'hFFFF, 32);
        drive_slot(1'b0, 16'h2468, 32); drive_slot(1'b1, 16'hFFFF, 32);
        drive_slot(1'b0, 16'h9ABC, 32); drive_slot(1'b1, 16'hFFFF, 32);
        drive_slot(1'b0, 16'hFEDC, 32); drive_slot(1'b1, 16'hFFFF, 32);
        exp_q = '{17'h01357, 17'h02468, 17'h09ABC, 17'h0FEDC};
        check_stream("mono_stream");
        chk("mono_num", receive_num, 4);

        // back-pressure: second sample dropped
        setup(1'b0, 1'b0, 32'd0);
        out_ready = 1'b0;
        drive_slot(1'b0, 16'hA5C3, 32);
        drive_slot(1'b1, 16'h1234, 32);
        chk("ovr_valid", out_valid, 1);
        chk("ovr_data", out_data, 16'hA5C3);
        chk("ovr_chan", out_chan, 0);
        chk("ovr_flag", overrun, 1);
        chk("ovr_drop", drop_cnt, EXP_DROP);
        chk("ovr_num", receive_num, 1);
        out_ready = 1'b1;
        @(negedge clk);
        exp_q = '{17'h0A5C3};
        check_stream("ovr_stream");
        chk("ovr_valid_clr", out_valid, 0);

        // block count wraps at target_num
        setup(1'b0, 1'b0, 32'd3);
        drive_slot(1'b0, 16'h0001, 32); drive_slot(1'b1, 16'h0002, 32);
        drive_slot(1'b0, 16'h0003, 32);
        chk("tgt_num_wrap", receive_num, 0);
        chk("tgt_fin_n", fin_cnt, 1);
        drive_slot(1'b1, 16'h0004, 32);
        chk("tgt_num_after", receive_num, 1);
        chk("tgt_fin_once", fin_cnt, 1);
        exp_q = '{17'h00001, 17'h10002, 17'h00003, 17'h10004};
        check_stream("tgt_stream");

        // early WS edge after 8 bits
        setup(1'b0, 1'b0, 32'd0);
        drive_slot(1'b0, 16'hBEEF, 8);
        drive_slot(1'b1, 16'h0F0F, 32);
        exp_q = '{17'h10F0F};
        check_stream("ferr_stream");
        chk("ferr_flag", frame_err, 1);
        chk("ferr_num", receive_num, 1);

        // asynchronous reset mid-SHIFT
        setup(1'b0, 1'b0, 32'd0);
        out_ready = 1'b0;
        drive_slot(1'b0, 16'hC0DE, 32);
        drive_slot(1'b1, 16'h1111, 8);
        chk("arst_pre_state", dbg_state, SHIFT);
        chk("arst_pre_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_num", receive_num, 0);
        chk("arst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b0;

        // rx_en low mid-SHIFT
        setup(1'b0, 1'b0, 32'd0);
        drive_slot(1'b0, 16'h5A5A, 8);
        chk("dis_pre_state", dbg_state, SHIFT);
        @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        chk("dis_state", dbg_state, IDLE);
        repeat (20) @(negedge clk);
        chk("dis_count", got_q.size(), 0);
        chk("dis_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
